// File: rtl/bht_ctrl.sv
// Branch history table scheduler: clear sweep after reset, then arbitrates the single RAM port
// between fetch lookups and buffered execute updates. Optional macro BHT_BYPASS_EN forwards pending updates to lookups.
module bht_ctrl #(
  parameter int          IDX_W    = 10,
  parameter int          UQ_DEPTH = 4,
  parameter logic [1:0]  INIT_CNT = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lu_valid,
  input  logic [31:0]      lu_pc,
  output logic             lu_ready,
  output logic             lu_resp_valid,
  output logic [1:0]       lu_pred,
  output logic             lu_taken,
  input  logic             up_valid,
  input  logic [31:0]      up_pc,
  input  logic [1:0]       up_cnt,
  input  logic             up_taken,
  output logic             up_ready,
  output logic             ram_en,
  output logic             ram_we,
  output logic [IDX_W-1:0] ram_addr,
  output logic [1:0]       ram_wdata,
  input  logic [1:0]       ram_rdata,
  output logic             busy
);

  localparam int                PTR_W    = $clog2(UQ_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]    CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]    CNT_FULL = (PTR_W+1)'(UQ_DEPTH);
  localparam logic [IDX_W-1:0]  IDX_LAST = {IDX_W{1'b1}};

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t           state_r, state_nx;
  logic [IDX_W-1:0] sweep_addr_r;
  logic [IDX_W-1:0] q_idx_r [UQ_DEPTH];
  logic [1:0]       q_cnt_r [UQ_DEPTH];
  logic [PTR_W-1:0] head_r, tail_r;
  logic [PTR_W:0]   count_r;
  logic             resp_valid_r, byp_hit_r;
  logic [1:0]       byp_cnt_r, lu_pred_r;

  logic             full_s, empty_s, lu_acc_s, up_acc_s, pop_s;
  logic             ram_en_s, ram_we_s, byp_hit_s;
  logic [IDX_W-1:0] lu_idx_s, up_idx_s;
  logic [1:0]       up_newcnt_s, byp_cnt_s;
  logic             unused_ok;

  // Saturating 2-bit counter step toward the resolved direction.
  function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (cnt == 2'd3) ? 2'd3 : cnt + 2'd1;
    end else begin
      res = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
    end
    return res;
  endfunction

  assign lu_idx_s    = lu_pc[IDX_W+1:2];
  assign up_idx_s    = up_pc[IDX_W+1:2];
  assign up_newcnt_s = sat_next(up_cnt, up_taken);
  assign full_s      = (count_r == CNT_FULL);
  assign empty_s     = (count_r == '0);
  assign unused_ok   = ^{lu_pc[31:IDX_W+2], lu_pc[1:0], up_pc[31:IDX_W+2], up_pc[1:0]};

  // Next state and RAM port arbitration: sweep, then lookup, then drain.
  always_comb begin
    state_nx  = state_r;
    ram_en_s  = 1'b0;
    ram_we_s  = 1'b0;
    ram_addr  = '0;
    ram_wdata = 2'b00;
    lu_ready  = 1'b0;
    up_ready  = 1'b0;
    lu_acc_s  = 1'b0;
    up_acc_s  = 1'b0;
    pop_s     = 1'b0;
    case (state_r)
      INIT: begin
        ram_en_s  = 1'b1;
        ram_we_s  = 1'b1;
        ram_addr  = sweep_addr_r;
        ram_wdata = INIT_CNT;
        if (sweep_addr_r == IDX_LAST) begin
          state_nx = RUN;
        end else begin
          state_nx = INIT;
        end
      end
      RUN: begin
        lu_ready = !full_s && !rst;
        up_ready = !full_s && !rst;
        lu_acc_s = lu_valid && lu_ready;
        up_acc_s = up_valid && up_ready;
        if (lu_acc_s) begin
          ram_en_s = 1'b1;
          ram_addr = lu_idx_s;
        end else if (!empty_s) begin
          ram_en_s  = 1'b1;
          ram_we_s  = 1'b1;
          ram_addr  = q_idx_r[head_r];
          ram_wdata = q_cnt_r[head_r];
          pop_s     = 1'b1;
        end else begin
          ram_en_s = 1'b0;
        end
      end
      default: state_nx = INIT;
    endcase
  end

  assign ram_en = ram_en_s && !rst;
  assign ram_we = ram_we_s && !rst;
  assign busy   = (state_r == INIT);

`ifdef BHT_BYPASS_EN
  logic [PTR_W-1:0] slot_s;

  // Newest pending update for the lookup index; a same-cycle enqueue is newer than any stored entry.
  always_comb begin
    byp_hit_s = 1'b0;
    byp_cnt_s = 2'b00;
    slot_s    = head_r;
    for (int i = 0; i < UQ_DEPTH; i++) begin
      slot_s = head_r + PTR_W'(i);
      if (((PTR_W+1)'(i) < count_r) && (q_idx_r[slot_s] == lu_idx_s)) begin
        byp_hit_s = 1'b1;
        byp_cnt_s = q_cnt_r[slot_s];
      end else begin
        byp_hit_s = byp_hit_s;
      end
    end
    if (up_acc_s && (up_idx_s == lu_idx_s)) begin
      byp_hit_s = 1'b1;
      byp_cnt_s = up_newcnt_s;
    end else begin
      byp_hit_s = byp_hit_s;
    end
  end
`else
  assign byp_hit_s = 1'b0;
  assign byp_cnt_s = 2'b00;
`endif

  // State register and sweep address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= INIT;
      sweep_addr_r <= '0;
    end else begin
      state_r <= state_nx;
      if (state_r == INIT) begin
        sweep_addr_r <= sweep_addr_r + {{(IDX_W-1){1'b0}}, 1'b1};
      end else begin
        sweep_addr_r <= sweep_addr_r;
      end
    end
  end

  // Update FIFO storage and pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      for (int i = 0; i < UQ_DEPTH; i++) begin
        q_idx_r[i] <= '0;
        q_cnt_r[i] <= 2'b00;
      end
    end else begin
      if (up_acc_s) begin
        q_idx_r[tail_r] <= up_idx_s;
        q_cnt_r[tail_r] <= up_newcnt_s;
        tail_r          <= tail_r + PTR_ONE;
      end else begin
        tail_r <= tail_r;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end else begin
        head_r <= head_r;
      end
      case ({up_acc_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Lookup response pipeline; the prediction holds between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_r <= 1'b0;
      byp_hit_r    <= 1'b0;
      byp_cnt_r    <= 2'b00;
      lu_pred_r    <= 2'b00;
    end else begin
      resp_valid_r <= lu_acc_s;
      byp_hit_r    <= lu_acc_s ? byp_hit_s : 1'b0;
      byp_cnt_r    <= lu_acc_s ? byp_cnt_s : byp_cnt_r;
      lu_pred_r    <= lu_pred;
    end
  end

  assign lu_resp_valid = resp_valid_r;
  assign lu_pred       = resp_valid_r ? (byp_hit_r ? byp_cnt_r : ram_rdata) : lu_pred_r;
  assign lu_taken      = lu_pred[1];

endmodule

// File: tb/tb_bht_ctrl.sv
// Scoreboard bench for bht_ctrl: a bench-owned RAM, a table/queue reference model,
// a predictor that queues expectations on acceptance and a checker that pops them.
module tb_bht_ctrl;
  localparam int IDX_W   = 10;
  localparam int DEPTH   = 4;
  localparam int ENTRIES = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             lu_valid = 1'b0, up_valid = 1'b0, up_taken = 1'b0;
  logic [31:0]      lu_pc = 32'd0, up_pc = 32'd0;
  logic [1:0]       up_cnt = 2'd0;
  logic             lu_ready, lu_resp_valid, lu_taken, up_ready, ram_en, ram_we, busy;
  logic [1:0]       lu_pred, ram_wdata;
  logic [1:0]       ram_rdata = 2'b00;
  logic [IDX_W-1:0] ram_addr;

  bht_ctrl #(.IDX_W(IDX_W), .UQ_DEPTH(DEPTH), .INIT_CNT(2'b01)) dut (
    .clk(clk), .rst(rst),
    .lu_valid(lu_valid), .lu_pc(lu_pc), .lu_ready(lu_ready),
    .lu_resp_valid(lu_resp_valid), .lu_pred(lu_pred), .lu_taken(lu_taken),
    .up_valid(up_valid), .up_pc(up_pc), .up_cnt(up_cnt), .up_taken(up_taken), .up_ready(up_ready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Storage array the controller drives.
  logic [1:0] mem [ENTRIES];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] idx_of(input logic [31:0] pc);
    return pc[IDX_W+1:2];
  endfunction

  function automatic int sat_ref(input int cnt, input bit taken);
    int r;
    r = taken ? cnt + 1 : cnt - 1;
    if (r > 3) r = 3;
    if (r < 0) r = 0;
    return r;
  endfunction

  // Reference model state.
  logic [1:0]  ref_tbl [ENTRIES];
  logic [11:0] pending[$];
  logic [1:0]  exp_resp[$];
  logic [11:0] wlog[$];
  bit          run_m = 1'b0;
  int          sweep_exp = 0;
  int          resp_cnt = 0;
  logic [1:0]  last_pred_m = 2'b00;

  // Checker: compares what the DUT presents this cycle against the model.
  always @(negedge clk) begin
    logic [11:0] w;
    logic [1:0]  e;
    if (rst) begin
      chk("reset_outputs", {ram_en, ram_we, lu_ready, up_ready, lu_resp_valid, busy, lu_pred, lu_taken},
          {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0});
      pending.delete(); exp_resp.delete(); wlog.delete();
      run_m = 1'b0; sweep_exp = 0; resp_cnt = 0; last_pred_m = 2'b00;
    end else begin
      chk("busy", busy, !run_m);
      if (!run_m) begin
        chk("sweep_write", {ram_en, ram_we, lu_ready, up_ready, ram_addr, ram_wdata},
            {1'b1, 1'b1, 1'b0, 1'b0, sweep_exp[9:0], 2'b01});
        ref_tbl[sweep_exp] = 2'b01;
        sweep_exp++;
        if (sweep_exp == ENTRIES) run_m = 1'b1;
      end else begin
        chk("ready", {lu_ready, up_ready}, {2{pending.size() < DEPTH}});
        if (lu_valid && lu_ready) begin
          chk("lookup_read", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, idx_of(lu_pc)});
        end else if (ram_en && ram_we) begin
          if (pending.size() == 0) begin
            chk("unexpected_write", {ram_addr, ram_wdata}, 32'hFFFF_FFFF);
          end else begin
            w = pending.pop_front();
            chk("drain_write", {ram_addr, ram_wdata}, w);
            ref_tbl[w[11:2]] = w[1:0];
          end
          wlog.push_back({ram_addr, ram_wdata});
        end else begin
          chk("drain_required", {ram_en, 1'b0, pending.size() != 0}, 3'b000);
        end
      end
      chk("resp_valid", lu_resp_valid, exp_resp.size() != 0);
      if (lu_resp_valid) begin
        resp_cnt++;
        if (exp_resp.size() != 0) begin
          e = exp_resp.pop_front();
          chk("resp_pred", {lu_pred, lu_taken}, {e, e[1]});
          last_pred_m = e;
        end
      end else begin
        chk("pred_hold", lu_pred, last_pred_m);
      end
    end
  end

  // Predictor: records accepted updates and the value each accepted lookup must return.
  always @(negedge clk) begin
    logic [1:0] e;
    logic [9:0] li;
    #1;
    if (!rst && run_m) begin
      if (up_valid && up_ready)
        pending.push_back({idx_of(up_pc), 2'(sat_ref(int'(up_cnt), up_taken))});
      if (lu_valid && lu_ready) begin
        li = idx_of(lu_pc);
        e  = ref_tbl[li];
`ifdef BHT_BYPASS_EN
        for (int k = pending.size() - 1; k >= 0; k--) begin
          if (pending[k][11:2] == li) begin
            e = pending[k][1:0];
            break;
          end
        end
`endif
        exp_resp.push_back(e);
      end
    end
  end

  task automatic idle(input int n);
    lu_valid = 1'b0; up_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_run();
    int i;
    for (i = 0; i < ENTRIES + 20; i++) begin
      @(negedge clk); #2;
      if (!busy) break;
    end
    chk("sweep_timeout", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic send_up(input logic [31:0] pc, input logic [1:0] cnt, input logic tk);
    bit acc = 1'b0;
    up_valid = 1'b1; up_pc = pc; up_cnt = cnt; up_taken = tk;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk); acc = up_ready;
      @(posedge clk); #1;
    end
    chk("up_timeout", acc, 1'b1);
    up_valid = 1'b0;
  endtask

  task automatic send_lu(input logic [31:0] pc);
    bit acc = 1'b0;
    lu_valid = 1'b1; lu_pc = pc;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk); acc = lu_ready;
      @(posedge clk); #1;
    end
    chk("lu_timeout", acc, 1'b1);
    lu_valid = 1'b0;
  endtask

  initial begin
    int low_cnt;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    wait_run();
    idle(2);

    // Three updates with no lookups drain in acceptance order.
    wlog.delete();
    send_up(32'h20, 2'd3, 1'b1);
    send_up(32'h24, 2'd0, 1'b0);
    send_up(32'h28, 2'd1, 1'b1);
    idle(4);
    chk("order_count", wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk("order_w0", wlog[0], {10'd8, 2'd3});
      chk("order_w1", wlog[1], {10'd9, 2'd0});
      chk("order_w2", wlog[2], {10'd10, 2'd2});
    end

    // Entry 4 becomes 2'b10, then a lookup of pc 0x10 reads it.
    send_up(32'h10, 2'd1, 1'b1);
    idle(3);
    send_lu(32'h10);
    @(negedge clk); #2;
    chk("lookup_pred", {last_pred_m, lu_taken}, {2'b10, 1'b1});
    idle(2);

    // Lookups every cycle while four updates fill the FIFO: exactly one stall cycle.
    lu_valid = 1'b1; lu_pc = 32'h100;
    for (int i = 0; i < 4; i++) send_up(32'h118 + 32'(i * 4), 2'(i), 1'b1);
    low_cnt = 0;
    repeat (6) begin
      @(negedge clk); #2;
      if (!lu_ready) low_cnt++;
      @(posedge clk); #1;
    end
    chk("full_stall_cycles", low_cnt, 1);
    idle(6);

    // Update and lookup to idx 5 in the same cycle.
    lu_valid = 1'b1; lu_pc = 32'h14;
    up_valid = 1'b1; up_pc = 32'h14; up_cnt = 2'd2; up_taken = 1'b1;
    @(posedge clk); #1;
    idle(0);
    @(negedge clk); #2;
`ifdef BHT_BYPASS_EN
    chk("bypass_pred", last_pred_m, 2'd3);
`else
    chk("bypass_pred", last_pred_m, 2'd1);
`endif
    idle(4);

    // Random traffic on a small index range to provoke collisions.
    for (int c = 0; c < 1500; c++) begin
      lu_valid = 1'($urandom_range(0, 1));
      lu_pc    = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
      up_valid = 1'($urandom_range(0, 1));
      up_pc    = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
      up_cnt   = 2'($urandom_range(0, 3));
      up_taken = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    idle(10);

    // Reset mid-run with two updates pending and a lookup in flight.
    lu_valid = 1'b1; lu_pc = 32'h80;
    up_valid = 1'b1; up_pc = 32'h40; up_cnt = 2'd0; up_taken = 1'b1;
    @(posedge clk); #1;
    up_pc = 32'h44;
    @(posedge clk); #1;
    up_valid = 1'b0;
    @(posedge clk); #1;
    lu_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_run();
    idle(8);
    chk("reset_no_writes", wlog.size(), 0);
    chk("reset_no_resp", resp_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
